me_sched_ctrl: RTL and testbench

//  Sequencer for the SHA-256 message-expansion (ME) unit. Accepts one 512-bit block as 16 words

---
 rtl/sha256_pkg.sv | 16 +
 rtl/me_sched_ctrl.sv | 120 ++++++++++++
 tb/tb_me_sched_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-expansion sequencing logic.
package sha256_pkg;

  localparam int NUM_WORDS  = 16;
  localparam int NUM_ROUNDS = 64;
  localparam int CNT_W      = 7;

  // State encodings double as the ME state code driven onto me_fsm_out.
  typedef enum logic [2:0] {
    ME_IDLE   = 3'b000,
    ME_LOAD   = 3'b010,
    ME_EXPAND = 3'b011,
    ME_DONE   = 3'b100
  } me_state_e;

endpackage

// File: rtl/me_sched_ctrl.sv
// Sequencer for the SHA-256 message-expansion unit: loads 16 message words
// into the ME array, then steps it through rounds 0..63 and forwards each
// W[t] to the round engine over a valid/ready handshake.
module me_sched_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = sha256_pkg::NUM_WORDS,
  parameter int NUM_ROUNDS = sha256_pkg::NUM_ROUNDS,
  parameter int CNT_W      = sha256_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [DATA_WIDTH-1:0] s_data_in,
  input  logic                  s_valid_in,
  output logic                  s_ready_out,
  output logic [2:0]            me_fsm_out,
  output logic [CNT_W-1:0]      me_count_out,
  output logic [DATA_WIDTH-1:0] me_data_out,
  input  logic [DATA_WIDTH-1:0] me_w_in,
  output logic [DATA_WIDTH-1:0] w_data_out,
  output logic [CNT_W-1:0]      w_round_out,
  output logic                  w_valid_out,
  input  logic                  w_ready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  import sha256_pkg::*;

  localparam logic [CNT_W-1:0] LOAD_END  = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

  me_state_e             state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] data, data_nx;
  logic                  load_acc;
  logic                  w_acc;

  assign load_acc = s_valid_in && s_ready_out;
  assign w_acc    = w_valid_out && w_ready_in;

  // State, counter and ME data registers; the data word is cleared on reset
  // so every output reads zero, while the ME array itself is left alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ME_IDLE;
      cnt   <= '0;
      data  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      data  <= data_nx;
    end
  end

  // Next-state logic; abort overrides any start or handshake in the same cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = data;
    if (abort_in) begin
      state_nx = ME_IDLE;
      cnt_nx   = '0;
      data_nx  = '0;
    end else begin
      unique case (state)
        ME_IDLE: begin
          if (start_in) begin
            state_nx = ME_LOAD;
            cnt_nx   = '0;
          end
        end
        ME_LOAD: begin
          // cnt == 16 is the commit cycle in which the ME writes word 15.
          if (cnt == LOAD_END) begin
            state_nx = ME_EXPAND;
            cnt_nx   = '0;
          end else if (load_acc) begin
            cnt_nx  = cnt + 1'b1;
            data_nx = s_data_in;
          end
        end
        ME_EXPAND: begin
          if (w_acc) begin
            if (cnt == LAST_ROUND) begin
              state_nx = ME_DONE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        ME_DONE: begin
          state_nx = ME_IDLE;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = ME_IDLE;
          cnt_nx   = '0;
          data_nx  = '0;
        end
      endcase
    end
  end

  // Output decode from the registered state; W[t] passes straight through.
  always_comb begin
    me_fsm_out   = state;
    me_count_out = cnt;
    me_data_out  = data;
    s_ready_out  = (state == ME_LOAD) && (cnt < LOAD_END);
    w_valid_out  = (state == ME_EXPAND);
    w_round_out  = (state == ME_EXPAND) ? cnt : '0;
    w_data_out   = (state == ME_EXPAND) ? me_w_in : '0;
    busy_out     = (state != ME_IDLE);
    done_out     = (state == ME_DONE);
  end

endmodule

// File: tb/tb_me_sched_ctrl.sv
// Directed bench for me_sched_ctrl with a behavioural ME array and a
// reference SHA-256 message schedule.
module tb_me_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_in, abort_in, s_valid_in, s_ready_out;
  logic [31:0] s_data_in, me_data_out, me_w_in, w_data_out;
  logic [2:0]  me_fsm_out;
  logic [6:0]  me_count_out, w_round_out;
  logic        w_valid_out, w_ready_in, busy_out, done_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cyc0    = 0;
  int c;

  logic [31:0] blk[16];
  logic [31:0] refw[64];
  logic [31:0] got[64];
  logic [31:0] mem[64];

  always #5 clk = ~clk;

  me_sched_ctrl dut (
    .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
    .s_data_in(s_data_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .me_fsm_out(me_fsm_out), .me_count_out(me_count_out), .me_data_out(me_data_out),
    .me_w_in(me_w_in), .w_data_out(w_data_out), .w_round_out(w_round_out),
    .w_valid_out(w_valid_out), .w_ready_in(w_ready_in),
    .busy_out(busy_out), .done_out(done_out)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sg0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sg1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Behavioural ME unit driven by the controller's state code and counter.
  always @* begin
    c = int'(me_count_out);
    if (c < 16)      me_w_in = mem[c];
    else if (c < 64) me_w_in = sg1(mem[c-2]) + mem[c-7] + sg0(mem[c-15]) + mem[c-16];
    else             me_w_in = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (me_fsm_out == 3'b010 && me_count_out != 0 && me_count_out <= 16)
      mem[me_count_out - 1] <= me_data_out;
    if (me_fsm_out == 3'b011 && me_count_out == 0)
      mem[15] <= me_data_out;
    if (me_fsm_out == 3'b011 && me_count_out >= 16 && me_count_out < 64)
      mem[me_count_out] <= me_w_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic compute_ref();
    for (int i = 0; i < 16; i++) refw[i] = blk[i];
    for (int i = 16; i < 64; i++)
      refw[i] = sg1(refw[i-2]) + refw[i-7] + sg0(refw[i-15]) + refw[i-16];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " fsm"},    32'(me_fsm_out), 32'h0);
    chk({tag, " count"},  32'(me_count_out), 32'h0);
    chk({tag, " mdata"},  me_data_out, 32'h0);
    chk({tag, " wvalid"}, {w_valid_out, w_round_out, s_ready_out, busy_out, done_out}, 32'h0);
    chk({tag, " wdata"},  w_data_out, 32'h0);
  endtask

  // Start a block and load all 16 words; returns in the first EXPAND cycle.
  task automatic do_load(input string tag, input int gap);
    int k, guard, skip, dbad;
    k = 0; guard = 0; skip = 0; dbad = 0;
    cyc0 = cyc;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk({tag, " load entry"}, {29'h0, me_fsm_out}, 32'h2);
    while (k < 16 && guard < 400) begin
      s_valid_in = (gap == 0) || ($urandom_range(99) >= gap);
      s_data_in  = s_valid_in ? blk[k] : $urandom;
      if (int'(me_count_out) != k) skip++;
      if (k > 0 && me_data_out !== blk[k-1]) dbad++;
      if (s_valid_in && s_ready_out) k++;
      tick();
      guard++;
    end
    s_valid_in = 1'b0;
    chk({tag, " words accepted"}, k, 16);
    chk({tag, " count skips"}, skip, 0);
    chk({tag, " load data hold"}, dbad, 0);
    chk({tag, " commit"}, {me_fsm_out, me_count_out, s_ready_out}, {3'b010, 7'd16, 1'b0});
    if (gap == 0) chk({tag, " commit cycle"}, cyc - cyc0, 17);
    tick();
    chk({tag, " expand entry"}, {me_fsm_out, me_data_out}, {3'b011, blk[15]});
    if (gap == 0) chk({tag, " first W cycle"}, cyc - cyc0, 18);
  endtask

  // Consume W[0..63] with an optional stall, then check DONE and return to IDLE.
  task automatic do_expand(input string tag, input int stall_t, input int stall_len, input bit timing);
    int t, guard, ebad, sbad, left;
    logic [31:0] held;
    t = 0; guard = 0; ebad = 0; sbad = 0; left = stall_len; held = '0;
    while (t < 64 && guard < 400) begin
      start_in = (t == 30);
      if (!w_valid_out || int'(w_round_out) != t || me_fsm_out != 3'b011) ebad++;
      if (t == stall_t && left == stall_len) held = w_data_out;
      if (t == stall_t && w_data_out !== held) sbad++;
      if (t == stall_t && left > 0) begin
        w_ready_in = 1'b0;
        left--;
      end else begin
        w_ready_in = 1'b1;
        got[t] = w_data_out;
        t++;
      end
      tick();
      guard++;
    end
    w_ready_in = 1'b0;
    start_in = 1'b1;
    chk({tag, " rounds consumed"}, t, 64);
    chk({tag, " round sequence"}, ebad, 0);
    if (stall_len > 0) chk({tag, " stall hold"}, sbad, 0);
    chk({tag, " done"}, {done_out, busy_out, me_fsm_out, me_count_out}, {1'b1, 1'b1, 3'b100, 7'd0});
    if (timing) chk({tag, " done cycle"}, cyc - cyc0, 82);
    tick();
    start_in = 1'b0;
    chk({tag, " idle after done"}, {me_fsm_out, busy_out, done_out}, 5'b0);
    tick();
    chk({tag, " start in DONE ignored"}, 32'(me_fsm_out), 32'h0);
  endtask

  task automatic cmp_all(input string tag, input int from);
    int bad;
    bad = 0;
    for (int i = from; i < 64; i++) if (got[i] !== refw[i]) bad++;
    chk({tag, " W mismatches"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; abort_in = 1'b0; s_valid_in = 1'b0;
    s_data_in = '0; w_ready_in = 1'b0;
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // 1: "abc" block, no stalls
    blk[0] = 32'h6162_6380;
    for (int i = 1; i < 15; i++) blk[i] = '0;
    blk[15] = 32'h0000_0018;
    compute_ref();
    do_load("abc", 0);
    do_expand("abc", -1, 0, 1'b1);
    chk("abc W0",  got[0],  32'h6162_6380);
    chk("abc W15", got[15], 32'h0000_0018);
    chk("abc W16", got[16], 32'h6162_6380);
    chk("abc W63", got[63], 32'h12B1_EDEB);
    cmp_all("abc", 0);

    // 2: random input gaps
    for (int i = 0; i < 64; i++) got[i] = '0;
    do_load("gaps", 30);
    do_expand("gaps", -1, 0, 1'b0);
    cmp_all("gaps", 0);

    // 3: round engine stall at t=20
    for (int i = 0; i < 64; i++) got[i] = '0;
    do_load("stall", 0);
    do_expand("stall", 20, 5, 1'b0);
    cmp_all("stall", 20);

    // 4: abort at LOAD count 9, then a fresh block
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    cyc0 = cyc;
    start_in = 1'b1; tick(); start_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid_in = 1'b1; s_data_in = blk[i]; tick();
    end
    chk("abort pre count", 32'(me_count_out), 32'd9);
    abort_in = 1'b1; s_valid_in = 1'b1; s_data_in = blk[9];
    tick();
    abort_in = 1'b0; s_valid_in = 1'b0;
    chk_idle("abort load");
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    compute_ref();
    for (int i = 0; i < 64; i++) got[i] = '0;
    do_load("newblk", 0);
    do_expand("newblk", -1, 0, 1'b1);
    cmp_all("newblk", 0);

    // 5: abort together with start, in IDLE and in EXPAND
    abort_in = 1'b1; start_in = 1'b1; tick();
    abort_in = 1'b0; start_in = 1'b0;
    chk("abort+start idle", {29'h0, me_fsm_out}, 32'h0);
    do_load("abx", 0);
    w_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    abort_in = 1'b1; start_in = 1'b1; tick();
    abort_in = 1'b0; start_in = 1'b0; w_ready_in = 1'b0;
    chk_idle("abort+start expand");

    // 6: reset mid-EXPAND
    do_load("rstx", 0);
    w_ready_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("rst pre round", 32'(w_round_out), 32'd7);
    rst = 1'b1; tick();
    rst = 1'b0; w_ready_in = 1'b0;
    chk_idle("rst expand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
